// File: rtl/cvp_mem_responder.sv
// CVP14 memory-side responder: word-addressed SRAM that answers scalar and
// BURST_LEN-beat vector requests with a Ready strobe after a fixed wait.
module cvp_mem_responder #(
  parameter int DEPTH_LOG2  = 10,
  parameter int WAIT_STATES = 2,
  parameter int BURST_LEN   = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] Addr,
  input  logic        RD,
  input  logic        WR,
  input  logic        Burst,
  input  logic [15:0] DataW,
  output logic [15:0] DataR,
  output logic        Ready,
  output logic        Busy,
  output logic        Err
);

  localparam int DEPTH  = 1 << DEPTH_LOG2;
  localparam int BEAT_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_XFER
  } state_t;

  state_t                state, state_nxt;
  logic [3:0]            wait_cnt, wait_cnt_nxt;
  logic [BEAT_W-1:0]     beat_cnt, beat_nxt;
  logic [DEPTH_LOG2-1:0] addr_q, addr_nxt;
  logic                  is_wr, is_wr_nxt;
  logic                  is_burst, is_burst_nxt;
  logic                  err_nxt;
  logic                  last_beat;
  logic [15:0]           hold_q;
  logic [15:0]           mem [DEPTH];

  // Upper address bits alias onto the array and are intentionally dropped.
  logic unused_addr;
  assign unused_addr = ^Addr[15:DEPTH_LOG2];

  assign Ready     = (state == S_XFER);
  assign Busy      = (state != S_IDLE);
  assign last_beat = ~is_burst | (beat_cnt == BEAT_W'(BURST_LEN - 1));
  assign DataR     = (Ready && !is_wr) ? mem[addr_q] : hold_q;

  always_comb begin
    // NOTE: every signal gets a default before the case so no path infers a latch.
    state_nxt    = state;
    wait_cnt_nxt = wait_cnt;
    beat_nxt     = beat_cnt;
    addr_nxt     = addr_q;
    is_wr_nxt    = is_wr;
    is_burst_nxt = is_burst;
    err_nxt      = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (RD && WR) begin
          err_nxt = 1'b1;
        end else if (RD || WR) begin
          addr_nxt     = Addr[DEPTH_LOG2-1:0];
          is_wr_nxt    = WR;
          is_burst_nxt = Burst;
          wait_cnt_nxt = 4'(WAIT_STATES);
          beat_nxt     = '0;
          state_nxt    = (WAIT_STATES == 0) ? S_XFER : S_WAIT;
        end
      end
      S_WAIT: begin
        wait_cnt_nxt = wait_cnt - 4'd1;
        if (wait_cnt == 4'd1) state_nxt = S_XFER;
      end
      S_XFER: begin
        // Beat address wraps at the array top, not at a burst boundary.
        addr_nxt = addr_q + 1'b1;
        beat_nxt = beat_cnt + 1'b1;
        if (last_beat) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= S_IDLE;
      wait_cnt <= '0;
      beat_cnt <= '0;
      addr_q   <= '0;
      is_wr    <= 1'b0;
      is_burst <= 1'b0;
      Err      <= 1'b0;
      hold_q   <= '0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_cnt_nxt;
      beat_cnt <= beat_nxt;
      addr_q   <= addr_nxt;
      is_wr    <= is_wr_nxt;
      is_burst <= is_burst_nxt;
      Err      <= err_nxt;
      if (Ready && !is_wr) hold_q <= mem[addr_q];
    end
  end

  // NOTE: the array has no reset; contents must survive a reset pulse.
  always_ff @(posedge clk) begin
    if (Ready && is_wr) mem[addr_q] <= DataW;
  end

endmodule

// File: tb/tb_cvp_mem_responder.sv
// Scoreboard bench for cvp_mem_responder: one instance with two wait states
// and one with none, checked against a flat-array memory model.
module tb_cvp_mem_responder;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [15:0] Addr = '0;
  logic [15:0] DataW = '0;
  logic        RD = 1'b0, WR = 1'b0, Burst = 1'b0;
  logic [15:0] DataR_a, DataR_z, DataR_m;
  logic        Ready_a, Ready_z, Ready_m;
  logic        Busy_a, Busy_z, Busy_m;
  logic        Err_a, Err_z, Err_m;
  logic        sel = 1'b0;

  always #5 clk = ~clk;

  cvp_mem_responder #(.DEPTH_LOG2(10), .WAIT_STATES(2), .BURST_LEN(16)) dut_a (
    .clk(clk), .rst(rst), .Addr(Addr), .RD(RD), .WR(WR), .Burst(Burst),
    .DataW(DataW), .DataR(DataR_a), .Ready(Ready_a), .Busy(Busy_a), .Err(Err_a)
  );

  cvp_mem_responder #(.DEPTH_LOG2(10), .WAIT_STATES(0), .BURST_LEN(16)) dut_z (
    .clk(clk), .rst(rst), .Addr(Addr), .RD(RD), .WR(WR), .Burst(Burst),
    .DataW(DataW), .DataR(DataR_z), .Ready(Ready_z), .Busy(Busy_z), .Err(Err_z)
  );

  assign DataR_m = sel ? DataR_z : DataR_a;
  assign Ready_m = sel ? Ready_z : Ready_a;
  assign Busy_m  = sel ? Busy_z  : Busy_a;
  assign Err_m   = sel ? Err_z   : Err_a;

  typedef struct {
    int          cyc;
    bit          rd;
    bit          chk;
    logic [15:0] data;
  } exp_t;

  exp_t        sb[$];
  logic [15:0] mref  [1024];
  bit          known [1024];
  logic [15:0] wdata [16];
  int          cyc = 0, total = 0, bad = 0;
  int          busy_lo = 1, busy_hi = 0, err_cyc = -1, ws = 2;
  logic [15:0] exp_hold = '0;
  bit          hold_known = 1'b1;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h, expected %0h (cyc %0d)", name, act, req, cyc);
    end
  endtask

  // Monitor: every Ready pops one expected beat; Busy/Err/DataR hold checked each cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst) begin
        if (Ready_m) begin
          if (sb.size() == 0) begin
            total++;
            bad++;
            $display("FAIL extra_ready: Ready=1 with nothing outstanding (cyc %0d)", cyc);
          end else begin
            e = sb.pop_front();
            check("ready_cycle", cyc, e.cyc);
            if (e.rd) begin
              if (e.chk) check("read_data", DataR_m, e.data);
              hold_known = e.chk;
              exp_hold   = e.data;
            end
          end
        end else if (hold_known) begin
          check("datar_hold", DataR_m, exp_hold);
        end
        check("busy", Busy_m, (cyc >= busy_lo && cyc <= busy_hi));
        check("err", Err_m, (cyc == err_cyc));
      end
    end
  end

  task automatic wait_idle();
    int t;
    t = 0;
    do begin
      @(negedge clk);
      t++;
    end while ((Busy_m || sb.size() != 0) && t < 300);
    if (t >= 300) begin
      total++;
      bad++;
      $display("FAIL idle_timeout: Busy=%0b pending=%0d after %0d cycles", Busy_m, sb.size(), t);
    end
  endtask

  // Issues one request; abort_at pulls reset during that beat, poke_at pulses RD during that beat.
  task automatic issue(input bit wr, input bit bst, input logic [15:0] addr,
                       input int abort_at, input int poke_at);
    int          n, k, i, t;
    logic [9:0]  a;
    exp_t        e;
    wait_idle();
    n = bst ? 16 : 1;
    k = cyc + 1;
    for (int b = 0; b < n; b++) begin
      a      = addr[9:0] + 10'(b);
      e.cyc  = k + ws + b;
      e.rd   = !wr;
      e.chk  = wr ? 1'b0 : known[a];
      e.data = wr ? 16'h0 : mref[a];
      sb.push_back(e);
      if (wr && (abort_at < 0 || b < abort_at)) begin
        mref[a]  = wdata[b];
        known[a] = 1'b1;
      end
    end
    busy_lo = k;
    busy_hi = k + ws + n - 1;
    Addr  = addr;
    RD    = !wr;
    WR    = wr;
    Burst = bst;
    DataW = wdata[0];
    @(posedge clk);
    #1;
    RD    = 1'b0;
    WR    = 1'b0;
    Burst = 1'b0;
    Addr  = 16'($urandom);
    i = 0;
    t = 0;
    while (i < n && t < 100) begin
      @(negedge clk);
      t++;
      if (Ready_m) begin
        if (i == abort_at) begin
          #2 rst = 1'b0;
          sb.delete();
          busy_lo    = 1;
          busy_hi    = 0;
          exp_hold   = '0;
          hold_known = 1'b1;
          #1;
          check("abort_ready", Ready_m, 0);
          check("abort_busy", Busy_m, 0);
          check("abort_datar", DataR_m, 0);
          repeat (2) @(negedge clk);
          rst = 1'b1;
          i = n;
        end else begin
          if (i == poke_at) begin
            RD   = 1'b1;
            Addr = 16'h0099;
          end
          i++;
          @(posedge clk);
          #1;
          RD = 1'b0;
          if (i < n) DataW = wdata[i];
        end
      end
    end
    if (i < n) begin
      total++;
      bad++;
      $display("FAIL beat_timeout: saw %0d of %0d beats", i, n);
    end
  endtask

  task automatic issue_err(input logic [15:0] addr);
    wait_idle();
    err_cyc = cyc + 1;
    RD   = 1'b1;
    WR   = 1'b1;
    Addr = addr;
    @(posedge clk);
    #1;
    RD = 1'b0;
    WR = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic rand_txn(input int cnt);
    bit          wr, bst;
    logic [15:0] ad;
    for (int r = 0; r < cnt; r++) begin
      wr  = 1'($urandom_range(0, 1));
      bst = ($urandom_range(0, 3) == 0);
      ad  = {6'($urandom), ($urandom_range(0, 1) != 0) ? 10'($urandom_range(0, 47))
                                                        : 10'($urandom_range(1000, 1023))};
      for (int b = 0; b < 16; b++) wdata[b] = 16'($urandom);
      repeat ($urandom_range(0, 2)) @(negedge clk);
      issue(wr, bst, ad, -1, -1);
    end
  endtask

  task automatic fill(input logic [15:0] base);
    for (int b = 0; b < 16; b++) wdata[b] = base + 16'(b);
  endtask

  initial begin
    for (int j = 0; j < 1024; j++) begin
      mref[j]  = '0;
      known[j] = 1'b0;
    end
    repeat (3) @(negedge clk);
    check("rst_ready", Ready_m, 0);
    check("rst_busy", Busy_m, 0);
    check("rst_err", Err_m, 0);
    check("rst_datar", DataR_m, 0);
    rst = 1'b1;

    // Two wait states: scalar write/read, bursts, wrap/alias, Err, busy strobe, abort.
    wdata[0] = 16'hBEEF;
    issue(1'b1, 1'b0, 16'h0005, -1, -1);
    issue(1'b0, 1'b0, 16'h0005, -1, -1);
    fill(16'h1000);
    issue(1'b1, 1'b1, 16'h0020, -1, -1);
    issue(1'b0, 1'b1, 16'h0020, -1, 5);
    fill(16'h2000);
    issue(1'b1, 1'b1, 16'h03FC, -1, -1);
    issue(1'b0, 1'b0, 16'h0400, -1, -1);
    issue(1'b0, 1'b0, 16'h03FF, -1, -1);
    issue(1'b0, 1'b1, 16'hFFF8, -1, -1);
    issue_err(16'h0005);
    issue(1'b0, 1'b0, 16'h0005, -1, -1);
    fill(16'h3000);
    issue(1'b1, 1'b1, 16'h0200, -1, -1);
    fill(16'h4000);
    issue(1'b1, 1'b1, 16'h0200, 8, -1);
    issue(1'b0, 1'b1, 16'h0200, -1, -1);
    rand_txn(40);
    wait_idle();

    // Zero wait states: the other instance saw the same bus traffic, so forget its contents.
    sel = 1'b1;
    ws  = 0;
    hold_known = 1'b0;
    for (int j = 0; j < 1024; j++) known[j] = 1'b0;
    wdata[0] = 16'hCAFE;
    issue(1'b1, 1'b0, 16'h0011, -1, -1);
    issue(1'b0, 1'b0, 16'h0011, -1, -1);
    fill(16'h5000);
    issue(1'b1, 1'b1, 16'h0100, -1, -1);
    issue(1'b0, 1'b1, 16'h0100, -1, 3);
    fill(16'h6000);
    issue(1'b1, 1'b1, 16'h0300, -1, -1);
    fill(16'h7000);
    issue(1'b1, 1'b1, 16'h0300, 8, -1);
    issue(1'b0, 1'b1, 16'h0300, -1, -1);
    rand_txn(20);
    wait_idle();
    repeat (3) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
